binary_multiplier_4_bit: RTL and testbench
==========================================

BINARY_MULTIPLIER_4_BIT -- requirements
Module: binary_multiplier_4_bit

Interface
REQ-001 Parameters: none SHALL be declared; operand width SHALL be fixed at 4 bits to match adder_4_bit_df.
REQ-002 clock  input  1  SHALL be the single clock; all state updates on posedge.
REQ-003 reset  input  1  SHALL be asynchronous, active-high reset.
REQ-004 Start  input  1  SHALL request a multiply; sampled only in S_idle.
REQ-005 Multiplicand  input  4  SHALL be the unsigned operand B, captured on accepted Start.
REQ-006 Multiplier  input  4  SHALL be the unsigned operand Q, captured on accepted Start.
REQ-007 Product  output  8  SHALL be the unsigned result {A,Q}.
REQ-008 Ready  output  1  SHALL be 1 exactly when the state is S_idle.

Function
REQ-009 Internal registers: A[3:0], Q[3:0], B[3:0], carry C, down-counter P[2:0], state.
REQ-010 States: S_idle, S_add and S_shift; encodings SHALL be binary with S_idle = 0.
REQ-011 S_idle with Start=1: A<=0, C<=0, P<=4, B<=Multiplicand, Q<=Multiplier; next state S_add.
REQ-012 S_idle with Start=0: all registers SHALL hold, keeping the previous Product stable.
REQ-013 S_add: P<=P-1; if Q[0]=1, {C,A}<={C4,Sum} of adder(A,B,C0=0); else A and C hold; next state S_shift.
REQ-014 S_shift: {C,A,Q}<={C,A,Q}>>1 with 0 entering C; next state S_idle if P==0, else S_add.
REQ-015 Latency: Start accepted at edge k; Ready=0 from after edge k; Ready=1 and Product final after edge k+8.
REQ-016 Start asserted while Ready=0 SHALL be ignored; operand changes while busy SHALL have no effect.
REQ-017 Start held high in S_idle SHALL launch a new multiply at that edge, giving back-to-back operations with one idle cycle between them.
REQ-018 Product SHALL equal Multiplicand*Multiplier for all 256 input pairs; max 15*15=225 SHALL fit with no overflow.
REQ-019 Product during Ready=0 SHALL be intermediate and SHALL NOT be relied upon.

Reset
REQ-020 reset=1 SHALL immediately force S_idle and set A, Q, B, C and P to 0, independent of clock.
REQ-021 During and after reset, Product=8'h00 and Ready=1.
REQ-022 Reset mid-operation SHALL abort the multiply with no partial result retained.
REQ-023 First Start after reset release SHALL be accepted on the next posedge.

Structure
REQ-024 The shared package/include SHALL hold the state encodings (S_idle, S_add, S_shift), operand width 4, and iteration count 4.
REQ-025 The datapath addition SHALL use one instance of adder_4_bit_df (ports Sum, C4, A, B, C0) with C0 tied to 0.
REQ-026 The controller (state register and next-state logic) and datapath registers SHALL reside in this module; no other sub-modules.

Verification
REQ-027 Reset, then Multiplicand=4'hf, Multiplier=4'hf, Start for one cycle -> Ready low 8 cycles, then Product=8'he1, Ready=1.
REQ-028 Multiplicand=4'ha, Multiplier=4'h5 -> Product=8'h32; then 4'h5 x 4'ha -> Product=8'h32.
REQ-029 Multiplicand=4'h0, Multiplier=4'hf, and then 4'h7 x 4'h0 -> Product=8'h00 after 8 cycles each.
REQ-030 Start 3 x 4 and hold Start high; change operands to 2 x 2 at cycle 2 -> first Product=8'h0c; next launch uses 2 x 2 -> 8'h04.
REQ-031 Start 9 x 9; assert reset at cycle 3 for one cycle -> Ready=1 and Product=8'h00 immediately; a new 9 x 9 -> 8'h51.
REQ-032 Exhaustive loop over all 256 operand pairs -> each Product matches the reference product, each with exactly 8 busy cycles.

Source files
------------

// File: rtl/binary_multiplier_4_bit_pkg.sv
// rtl/binary_multiplier_4_bit_pkg.sv - shared constants and state encoding for the 4-bit shift-add multiplier
// Holds the operand width, the iteration count and the controller state encoding.
package binary_multiplier_4_bit_pkg;

    localparam int WIDTH      = 4;
    localparam int ITERATIONS = 4;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        S_idle  = 2'd0,
        S_add   = 2'd1,
        S_shift = 2'd2
    } state_t;

endpackage

// File: rtl/adder_4_bit_df.sv
// rtl/adder_4_bit_df.sv - 4-bit dataflow ripple adder used by the multiplier datapath
// Ports:
//   A, B  : 4-bit addends
//   C0    : carry in
//   Sum   : 4-bit sum
//   C4    : carry out
module adder_4_bit_df
    import binary_multiplier_4_bit_pkg::*;
(
    output logic [WIDTH-1:0] Sum,
    output logic             C4,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0
);

    assign {C4, Sum} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C0};

endmodule

// File: rtl/binary_multiplier_4_bit.sv
// rtl/binary_multiplier_4_bit.sv - sequential 4x4 unsigned shift-add multiplier
// Ports:
//   clock        : single clock, all state updates on posedge
//   reset        : asynchronous active-high reset
//   Start        : request a multiply, sampled only while idle
//   Multiplicand : operand B, captured when Start is accepted
//   Multiplier   : operand Q, captured when Start is accepted
//   Product      : {A,Q}, valid once Ready returns high
//   Ready        : high exactly while the controller is idle
module binary_multiplier_4_bit
    import binary_multiplier_4_bit_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Ready
);

    state_t             state;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   b;
    logic               c;
    logic [CNT_W-1:0]   p;

    logic [WIDTH-1:0]   sum;
    logic               c4;

    adder_4_bit_df u_adder (
        .Sum (sum),
        .C4  (c4),
        .A   (a),
        .B   (b),
        .C0  (1'b0)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_idle;
            a     <= '0;
            q     <= '0;
            b     <= '0;
            c     <= 1'b0;
            p     <= '0;
        end else begin
            case (state)
                S_idle: begin
                    // Without Start every register holds so the last Product stays visible.
                    if (Start) begin
                        a     <= '0;
                        c     <= 1'b0;
                        p     <= CNT_W'(ITERATIONS);
                        b     <= Multiplicand;
                        q     <= Multiplier;
                        state <= S_add;
                    end
                end
                S_add: begin
                    p <= p - CNT_W'(1);
                    if (q[0]) begin
                        a <= sum;
                        c <= c4;
                    end
                    state <= S_shift;
                end
                S_shift: begin
                    // Shift {C,A,Q} right by one; the consumed multiplier bit falls off Q[0].
                    {c, a, q} <= {1'b0, c, a, q[WIDTH-1:1]};
                    // p was decremented in the preceding add, so zero means the last bit is done.
                    state <= (p == '0) ? S_idle : S_add;
                end
                default: begin
                    state <= S_idle;
                end
            endcase
        end
    end

    assign Product = {a, q};
    assign Ready   = (state == S_idle);

endmodule

// File: tb/tb_binary_multiplier_4_bit.sv
// tb/tb_binary_multiplier_4_bit.sv - scoreboard bench for the 4-bit shift-add multiplier
module tb_binary_multiplier_4_bit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       Start = 1'b0;
    logic [3:0] Multiplicand = 4'h0;
    logic [3:0] Multiplier   = 4'h0;
    logic [7:0] Product;
    logic       Ready;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         busy       = 0;
    logic       prev_ready = 1'b1;

    binary_multiplier_4_bit dut (
        .clock        (clock),
        .reset        (reset),
        .Start        (Start),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Product      (Product),
        .Ready        (Ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: a Ready rising edge marks a completed multiply; reset discards anything in flight.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            busy       = 0;
            prev_ready = 1'b1;
        end else if (!Ready) begin
            busy++;
            prev_ready = 1'b0;
        end else begin
            if (!prev_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion actual=%0h expected=none", Product);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("product", 32'(Product), 32'(e));
                    chk("busy_cycles", busy, 8);
                end
            end
            busy       = 0;
            prev_ready = 1'b1;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !Ready) && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("idle_timeout", 32'(n < 40), 1);
    endtask

    // Called away from the rising edge; Start is accepted at the next posedge.
    task automatic do_op(input logic [3:0] mb, input logic [3:0] mq, input bit noisy);
        chk("ready_before_start", 32'(Ready), 1);
        Multiplicand = mb;
        Multiplier   = mq;
        Start        = 1'b1;
        exp_q.push_back(8'(int'(mb) * int'(mq)));
        @(posedge clock);
        #1;
        Start = 1'b0;
        chk("accepted", 32'(Ready), 0);
        if (noisy) begin
            repeat (6) begin
                Start        = 1'($urandom_range(0, 1));
                Multiplicand = 4'($urandom);
                Multiplier   = 4'($urandom);
                @(posedge clock);
                #1;
            end
            Start = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        #1;
        chk("reset_product", 32'(Product), 0);
        chk("reset_ready", 32'(Ready), 1);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("post_reset_product", 32'(Product), 0);
        chk("post_reset_ready", 32'(Ready), 1);

        // First Start right after release, then directed corner cases.
        do_op(4'hf, 4'hf, 1'b0);
        do_op(4'ha, 4'h5, 1'b0);
        do_op(4'h5, 4'ha, 1'b0);
        do_op(4'h0, 4'hf, 1'b0);
        do_op(4'h7, 4'h0, 1'b0);

        // Start held high across completion: the second launch picks up 2 x 2.
        @(negedge clock);
        Multiplicand = 4'h3;
        Multiplier   = 4'h4;
        Start        = 1'b1;
        exp_q.push_back(8'h0c);
        exp_q.push_back(8'h04);
        @(posedge clock);
        #1;
        chk("b2b_accepted", 32'(Ready), 0);
        @(posedge clock);
        #1;
        Multiplicand = 4'h2;
        Multiplier   = 4'h2;
        n = 0;
        while (!Ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("b2b_first_done", 32'(Ready), 1);
        @(posedge clock);
        #1;
        Start = 1'b0;
        chk("b2b_second_launch", 32'(Ready), 0);
        wait_idle();

        // Reset mid-operation aborts the multiply.
        Multiplicand = 4'h9;
        Multiplier   = 4'h9;
        Start        = 1'b1;
        exp_q.push_back(8'h51);
        @(posedge clock);
        #1;
        Start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_product", 32'(Product), 0);
        chk("abort_ready", 32'(Ready), 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("abort_queue_flushed", exp_q.size(), 0);
        chk("abort_product_held", 32'(Product), 0);
        do_op(4'h9, 4'h9, 1'b0);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                do_op(4'(i), 4'(j), 1'b0);
            end
        end

        // Random operands with ignored Start/operand activity while busy.
        repeat (40) begin
            do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
